plot_framebuffer: RTL and testbench

On-chip 160x120 3-bit pixel store that receives the plot stream (x, y, colour, plot strobe) emitted by the circle/line drawing datapaths. It is the receiving end of the plot interface. It also provides a bulk clear engine and a raster-order read-back port with valid/ready handshake. The read-back port feeds the scan-out logic and the verification monitors.

---
 rtl/plot_framebuffer_if.sv | 28 ++
 rtl/plot_framebuffer.sv | 117 +++++++++++
 tb/tb_plot_framebuffer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/plot_framebuffer_if.sv
// Plot-stream, clear/scan control and raster read-back bundle for the framebuffer.
// The drawing/scan-out side uses master; the framebuffer uses slave.
interface plot_framebuffer_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       clear_start;
  logic       scan_start;
  logic       scan_ready;
  logic       busy;
  logic       plot_dropped;
  logic       scan_valid;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_colour;
  logic       scan_last;

  modport master (
    output x, y, colour, plot, clear_start, scan_start, scan_ready,
    input  busy, plot_dropped, scan_valid, scan_x, scan_y, scan_colour, scan_last
  );

  modport slave (
    input  x, y, colour, plot, clear_start, scan_start, scan_ready,
    output busy, plot_dropped, scan_valid, scan_x, scan_y, scan_colour, scan_last
  );
endinterface

// File: rtl/plot_framebuffer.sv
// WIDTH x HEIGHT 3-bit pixel store: plot writes land at the end of their cycle; bulk clear takes one cycle per pixel.
// Raster read-back: one beat per two cycles when ready is high; beats are held stable while scan_ready is low.
module plot_framebuffer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input logic             clock,
  input logic             resetb,
  plot_framebuffer_if.slave fb
);
  localparam int          NPIX      = WIDTH * HEIGHT;
  localparam logic [7:0]  X_LAST    = 8'(WIDTH - 1);
  localparam logic [6:0]  Y_LAST    = 7'(HEIGHT - 1);
  localparam logic [14:0] NPIX_LAST = 15'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN_RD, SCAN_OUT} state_t;

  state_t      state, state_nxt;
  logic [14:0] clr_addr;
  logic [7:0]  sx;
  logic [6:0]  sy;
  logic [2:0]  rd_dat;
  logic        plot_dropped_q;

  logic        plot_in_range, plot_ok, scan_last_pix, clr_done;
  logic        wr_en;
  logic [14:0] wr_addr, rd_addr;
  logic [2:0]  wr_dat;

  logic [2:0]  mem [0:NPIX-1];

  function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
    return 15'(py) * 15'(WIDTH) + 15'(px);
  endfunction

  assign plot_in_range = (fb.x <= X_LAST) && (fb.y <= Y_LAST);
  assign plot_ok       = fb.plot && plot_in_range && (state != CLEAR);
  assign scan_last_pix = (sx == X_LAST) && (sy == Y_LAST);
  assign clr_done      = (clr_addr == NPIX_LAST);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // clear has priority when both starts arrive together
        if (fb.clear_start)     state_nxt = CLEAR;
        else if (fb.scan_start) state_nxt = SCAN_RD;
      end
      CLEAR:    if (clr_done) state_nxt = IDLE;
      SCAN_RD:  state_nxt = SCAN_OUT;
      SCAN_OUT: if (fb.scan_ready) state_nxt = scan_last_pix ? IDLE : SCAN_RD;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      clr_addr <= '0;
      sx       <= '0;
      sy       <= '0;
    end else begin
      case (state)
        IDLE: begin
          clr_addr <= '0;
          sx       <= '0;
          sy       <= '0;
        end
        CLEAR: clr_addr <= clr_addr + 15'd1;
        SCAN_OUT: begin
          if (fb.scan_ready && !scan_last_pix) begin
            if (sx == X_LAST) begin
              sx <= '0;
              sy <= sy + 7'd1;
            end else begin
              sx <= sx + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The clear engine owns the single write port; plots are turned away meanwhile.
  assign wr_en   = (state == CLEAR) || plot_ok;
  assign wr_addr = (state == CLEAR) ? clr_addr : pix_addr(fb.x, fb.y);
  assign wr_dat  = (state == CLEAR) ? 3'b000 : fb.colour;
  assign rd_addr = pix_addr(sx, sy);

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Read register only loads in SCAN_RD, which keeps scan_colour steady under backpressure.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb)               rd_dat <= '0;
    else if (state == SCAN_RD) rd_dat <= mem[rd_addr];
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) plot_dropped_q <= 1'b0;
    else         plot_dropped_q <= fb.plot && (!plot_in_range || (state == CLEAR));
  end

  assign fb.busy         = (state != IDLE);
  assign fb.plot_dropped = plot_dropped_q;
  assign fb.scan_valid   = (state == SCAN_OUT);
  assign fb.scan_x       = sx;
  assign fb.scan_y       = sy;
  assign fb.scan_colour  = rd_dat;
  assign fb.scan_last    = (state == SCAN_OUT) && scan_last_pix;
endmodule

// File: tb/tb_plot_framebuffer.sv
// Directed bench for plot_framebuffer: clear, plots (in range, out of range, during clear),
// full raster scan under random backpressure, and reset in the middle of a clear.
module tb_plot_framebuffer;
  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic clock  = 1'b0;
  logic resetb = 1'b0;
  always #5 clock = ~clock;

  plot_framebuffer_if fb();

  plot_framebuffer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock  (clock),
    .resetb (resetb),
    .fb     (fb)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_img [NPIX];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic plot_px(input int px, input int py, input logic [2:0] c, input bit drop);
    fb.x      = 8'(px);
    fb.y      = 7'(py);
    fb.colour = c;
    fb.plot   = 1'b1;
    step();
    fb.plot = 1'b0;
    check($sformatf("drop_%0d_%0d", px, py), fb.plot_dropped, drop);
    if (!drop) exp_img[py*W+px] = c;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},         fb.busy,         0);
    check({tag, "_plot_dropped"}, fb.plot_dropped, 0);
    check({tag, "_scan_valid"},   fb.scan_valid,   0);
    check({tag, "_scan_x"},       fb.scan_x,       0);
    check({tag, "_scan_y"},       fb.scan_y,       0);
    check({tag, "_scan_colour"},  fb.scan_colour,  0);
    check({tag, "_scan_last"},    fb.scan_last,    0);
  endtask

  int n, idx, cyc, ex, ey, vbad, bad;
  int err_xy, err_col, err_last, err_hold, err_gap;
  bit rdy, gap_now, gap_due, prev_hold, done;
  logic [7:0] hx;
  logic [6:0] hy;
  logic [2:0] hc;

  initial begin
    fb.x = '0; fb.y = '0; fb.colour = '0; fb.plot = 1'b0;
    fb.clear_start = 1'b0; fb.scan_start = 1'b0; fb.scan_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) exp_img[i] = 3'b000;

    // reset state
    resetb = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    resetb = 1'b1;
    step();

    // full clear; plot in clear cycle 100 and in the final clear cycle, scan_start mid-clear
    fb.clear_start = 1'b1;
    step();
    fb.clear_start = 1'b0;
    check("clear_busy_rise", fb.busy, 1);
    n = 0;
    while (fb.busy && n < 20000) begin
      fb.plot = 1'b0;
      fb.scan_start = 1'b0;
      if (n == 101) check("drop_in_clear", fb.plot_dropped, 1);
      if (n == 100) begin fb.x = 8'd5; fb.y = 7'd5; fb.colour = 3'b010; fb.plot = 1'b1; end
      if (n == 200) fb.scan_start = 1'b1;
      if (n == 19199) begin fb.x = 8'd7; fb.y = 7'd7; fb.colour = 3'b011; fb.plot = 1'b1; end
      n++;
      step();
    end
    fb.plot = 1'b0;
    fb.scan_start = 1'b0;
    check("clear_cycles", n, NPIX);
    check("drop_last_clear_cycle", fb.plot_dropped, 1);

    // first plot in the cycle busy reads 0 is accepted
    plot_px(0, 0, 3'b100, 1'b0);
    check("scan_start_ignored_in_clear", fb.busy, 0);
    plot_px(30, 40, 3'b001, 1'b0);
    plot_px(80, 40, 3'b111, 1'b0);
    plot_px(160, 10, 3'b101, 1'b1);
    plot_px(10, 120, 3'b101, 1'b1);
    plot_px(255, 127, 3'b101, 1'b1);
    plot_px(159, 119, 3'b110, 1'b0);

    // full scan with random backpressure
    fb.scan_start = 1'b1;
    step();
    fb.scan_start = 1'b0;
    check("scan_busy", fb.busy, 1);
    check("scan_rd_no_valid", fb.scan_valid, 0);
    step();
    check("scan_first_valid", fb.scan_valid, 1);
    idx = 0; cyc = 0; done = 1'b0; gap_due = 1'b0; prev_hold = 1'b0;
    err_xy = 0; err_col = 0; err_last = 0; err_hold = 0; err_gap = 0;
    while (!done && cyc < 60000) begin
      rdy = ($urandom_range(0, 7) != 0);
      fb.scan_ready = rdy;
      gap_now = gap_due;
      gap_due = 1'b0;
      if (gap_now && fb.scan_valid) err_gap++;
      if (!gap_now && !fb.scan_valid) err_gap++;
      if (prev_hold && (!fb.scan_valid || fb.scan_x != hx || fb.scan_y != hy || fb.scan_colour != hc))
        err_hold++;
      prev_hold = 1'b0;
      if (fb.scan_valid) begin
        ex = idx % W;
        ey = idx / W;
        if (int'(fb.scan_x) != ex || int'(fb.scan_y) != ey) err_xy++;
        if (fb.scan_colour != exp_img[idx]) err_col++;
        if (fb.scan_last != (idx == NPIX - 1)) err_last++;
        if (rdy) begin
          case (idx)
            0:          check("pix_0_0",     fb.scan_colour, 3'b100);
            5*W+5:      check("pix_5_5",     fb.scan_colour, 3'b000);
            7*W+7:      check("pix_7_7",     fb.scan_colour, 3'b000);
            11*W:       check("pix_0_11",    fb.scan_colour, 3'b000);
            40*W+30:    check("pix_30_40",   fb.scan_colour, 3'b001);
            40*W+80:    check("pix_80_40",   fb.scan_colour, 3'b111);
            NPIX-1: begin
              check("pix_159_119", fb.scan_colour, 3'b110);
              check("last_flag",   fb.scan_last,   1);
            end
            default: ;
          endcase
          idx++;
          if (idx == NPIX) done = 1'b1;
          else gap_due = 1'b1;
        end else begin
          prev_hold = 1'b1;
          hx = fb.scan_x;
          hy = fb.scan_y;
          hc = fb.scan_colour;
        end
      end
      cyc++;
      step();
    end
    fb.scan_ready = 1'b0;
    check("scan_beats", idx, NPIX);
    check("scan_busy_fall", fb.busy, 0);
    check("scan_valid_after", fb.scan_valid, 0);
    check("scan_xy_errs", err_xy, 0);
    check("scan_colour_errs", err_col, 0);
    check("scan_last_errs", err_last, 0);
    check("scan_hold_errs", err_hold, 0);
    check("scan_gap_errs", err_gap, 0);

    // reset at clear cycle 5000; clear_start and scan_start together
    plot_px(10, 20, 3'b101, 1'b0);
    plot_px(39, 31, 3'b010, 1'b0);
    plot_px(40, 31, 3'b011, 1'b0);
    fb.clear_start = 1'b1;
    fb.scan_start  = 1'b1;
    step();
    fb.clear_start = 1'b0;
    fb.scan_start  = 1'b0;
    n = 0; vbad = 0;
    while (fb.busy && n < 5000) begin
      if (fb.scan_valid) vbad++;
      n++;
      step();
    end
    check("both_start_clear_wins", vbad, 0);
    check("clear_5000_cycles", n, 5000);
    check("clear_5000_busy", fb.busy, 1);
    resetb = 1'b0;
    #1;
    check_reset_outputs("midclear_rst");
    step();
    resetb = 1'b1;
    step();
    for (int i = 0; i < 5000; i++) exp_img[i] = 3'b000;

    // scan with ready held high up to address 5000
    fb.scan_ready = 1'b1;
    fb.scan_start = 1'b1;
    step();
    fb.scan_start = 1'b0;
    cyc = 1; idx = 0; bad = 0;
    while (idx <= 5000 && cyc < 12000) begin
      if (fb.scan_valid) begin
        if (fb.scan_colour != exp_img[idx] || int'(fb.scan_x) != idx % W || int'(fb.scan_y) != idx / W)
          bad++;
        if (idx == 3210) check("pix_10_20_cleared", fb.scan_colour, 3'b000);
        if (idx == 4999) check("pix_39_31_cleared", fb.scan_colour, 3'b000);
        if (idx == 5000) begin
          check("pix_40_31_kept", fb.scan_colour, 3'b011);
          check("beat5000_cycle", cyc, 10002);
        end
        idx++;
      end
      cyc++;
      step();
    end
    check("rst_scan_beats", idx, 5001);
    check("rst_scan_errs", bad, 0);
    resetb = 1'b0;
    step();
    check("abort_scan_busy", fb.busy, 0);
    resetb = 1'b1;
    fb.scan_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
